// File: rtl/keypad_entry.sv
// keypad_entry
//   Multi-slot decimal operand entry controller for the 24-game datapath.
//   Assembles NUM_SLOTS operands of up to DIGITS decimal digits each from
//   single-cycle key strobes. Supports enter, backspace and clear editing.
//
// Parameters
//   NUM_SLOTS  number of operands collected (1..8)
//   DIGITS     maximum decimal digits per operand (1..3)
//   VAL_W      bits per operand value (10**DIGITS-1 must fit)
//
// Ports
//   clk, rst    system clock; asynchronous active-high reset
//   key_strobe  one-cycle pulse qualifying key_code
//   key_code    0-9 digit, A enter, B backspace, C clear slot, D-F ignored
//   start       begin (or restart) an entry round
//   restart     abort to idle, clearing everything
//   slots       slot i value at bits [i*VAL_W +: VAL_W]
//   slot_valid  bit i set once slot i is committed
//   cur_slot    index of the slot being edited
//   cur_digits  digits typed into cur_slot
//   entering    high while in the ENTRY state
//   done        one-cycle pulse when the last slot commits
//   key_err     one-cycle pulse on a rejected key
module keypad_entry #(
  parameter int NUM_SLOTS = 4,
  parameter int DIGITS    = 2,
  parameter int VAL_W     = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       key_strobe,
  input  logic [3:0]                 key_code,
  input  logic                       start,
  input  logic                       restart,
  output logic [NUM_SLOTS*VAL_W-1:0] slots,
  output logic [NUM_SLOTS-1:0]       slot_valid,
  output logic [2:0]                 cur_slot,
  output logic [1:0]                 cur_digits,
  output logic                       entering,
  output logic                       done,
  output logic                       key_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ENTRY = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_BACK  = 4'hB;
  localparam logic [3:0] KEY_CLEAR = 4'hC;

  localparam logic [2:0]       LAST_SLOT  = 3'(NUM_SLOTS - 1);
  localparam logic [1:0]       MAX_DIGITS = 2'(DIGITS);
  localparam logic [VAL_W+3:0] TEN_EXT    = (VAL_W + 4)'(10);
  localparam logic [VAL_W-1:0] TEN        = VAL_W'(10);

  logic [1:0]       state;
  logic [VAL_W-1:0] slot_val [NUM_SLOTS];
  logic [1:0]       slot_cnt [NUM_SLOTS];

  logic [VAL_W-1:0] cur_val;
  logic [1:0]       prev_cnt;
  logic [VAL_W-1:0] val_push;
  logic [VAL_W-1:0] val_pop;

  // Select the slot under edit and the digit count of the slot before it
  // (needed when backspace reopens the previous slot).
  // NOTE: every signal gets a default before the loop; without it the
  // unmatched-index paths would infer latches.
  always_comb begin
    cur_val  = '0;
    prev_cnt = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (3'(i) == cur_slot)         cur_val  = slot_val[i];
      if (3'(i) == cur_slot - 3'd1)  prev_cnt = slot_cnt[i];
    end
  end

  // Shift in a digit at VAL_W+4 bits; the parameter rule guarantees the
  // result fits VAL_W bits, so the cast only drops zero bits.
  assign val_push = VAL_W'(({4'b0000, cur_val} * TEN_EXT) + {{VAL_W{1'b0}}, key_code});
  assign val_pop  = cur_val / TEN;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slots
    assign slots[g*VAL_W +: VAL_W] = slot_val[g];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // read in this block sees the pre-edge value.
  // NOTE: the slot register file is reset because its contents are outputs
  // that must read 0 during reset; it is small enough to be plain flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      slot_valid <= '0;
      cur_slot   <= '0;
      cur_digits <= '0;
      entering   <= 1'b0;
      done       <= 1'b0;
      key_err    <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_val[i] <= '0;
        slot_cnt[i] <= '0;
      end
    end else begin
      done    <= 1'b0;
      key_err <= 1'b0;

      if (restart || start) begin
        // Both clear the round; a key strobe in the same cycle is dropped.
        for (int i = 0; i < NUM_SLOTS; i++) begin
          slot_val[i] <= '0;
          slot_cnt[i] <= '0;
        end
        slot_valid <= '0;
        cur_slot   <= '0;
        cur_digits <= '0;
        state      <= restart ? S_IDLE : S_ENTRY;
        entering   <= !restart;
      end else if (key_strobe && state == S_ENTRY) begin
        if (key_code <= 4'd9) begin
          if (cur_digits < MAX_DIGITS) begin
            for (int i = 0; i < NUM_SLOTS; i++)
              if (3'(i) == cur_slot) slot_val[i] <= val_push;
            cur_digits <= cur_digits + 2'd1;
          end else begin
            key_err <= 1'b1;
          end
        end else begin
          case (key_code)
            KEY_ENTER: begin
              if (cur_digits == 2'd0) begin
                key_err <= 1'b1;
              end else begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                  if (3'(i) == cur_slot) begin
                    slot_valid[i] <= 1'b1;
                    slot_cnt[i]   <= cur_digits;
                  end
                end
                if (cur_slot == LAST_SLOT) begin
                  state    <= S_DONE;
                  entering <= 1'b0;
                  done     <= 1'b1;
                end else begin
                  cur_slot   <= cur_slot + 3'd1;
                  cur_digits <= 2'd0;
                end
              end
            end
            KEY_BACK: begin
              if (cur_digits != 2'd0) begin
                for (int i = 0; i < NUM_SLOTS; i++)
                  if (3'(i) == cur_slot) slot_val[i] <= val_pop;
                cur_digits <= cur_digits - 2'd1;
              end else if (cur_slot != 3'd0) begin
                // Reopen the previous slot with its committed value intact.
                for (int i = 0; i < NUM_SLOTS; i++)
                  if (3'(i) == cur_slot - 3'd1) slot_valid[i] <= 1'b0;
                cur_slot   <= cur_slot - 3'd1;
                cur_digits <= prev_cnt;
              end else begin
                key_err <= 1'b1;
              end
            end
            KEY_CLEAR: begin
              for (int i = 0; i < NUM_SLOTS; i++)
                if (3'(i) == cur_slot) slot_val[i] <= '0;
              cur_digits <= 2'd0;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: doc/keypad_entry.md
# keypad_entry

Parametrised multi-slot numeric entry controller for the 24-game datapath. It takes single-cycle key strobes from the keypad decoder and assembles NUM_SLOTS decimal operands of up to DIGITS digits each, with enter, backspace and clear editing. It presents the operands as a flat bus with per-slot valid flags for the number converter and VGA path. It generalises the fixed four-number, single-digit entry in the game FSM.

## Interface
- NUM_SLOTS, 4, number of operands collected (1..8)
- DIGITS, 2, maximum decimal digits per operand (1..3)
- VAL_W, 10, bits per operand value; must satisfy 10**DIGITS-1 <= 2**VAL_W-1
- clk  in  1  system clock (100 MHz)
- rst  in  1  reset; asynchronous, active-high
- key_strobe  in  1  one-cycle pulse, key_code valid
- key_code  in  4  keypad hex code: 0-9 digit, A enter, B backspace, C clear slot, D/E/F ignored
- start  in  1  debounced one-cycle pulse: begin a new entry round
- restart  in  1  debounced one-cycle pulse: abort to idle
- slots  out  NUM_SLOTS*VAL_W  slot i value at bits [i*VAL_W +: VAL_W]
- slot_valid  out  NUM_SLOTS  bit i set once slot i is committed
- cur_slot  out  3  index of the slot being edited
- cur_digits  out  2  digits typed into cur_slot
- entering  out  1  high in ENTRY state
- done  out  1  one-cycle pulse when the last slot commits
- key_err  out  1  one-cycle pulse on a rejected key

## Operation
- States: IDLE, ENTRY, DONE. Reset puts the block in IDLE. All slot values, slot_valid, cur_slot, cur_digits, entering, done and key_err are 0 in reset.
- Priority per cycle: rst > restart > start > key_strobe.
- restart in any state: go to IDLE and clear all slots, flags and counters.
- start in IDLE or DONE: go to ENTRY with all slots cleared, cur_slot=0, cur_digits=0. start in ENTRY clears and restarts the round.
- Keys outside ENTRY are ignored. They do not raise key_err.
- Digit d in ENTRY:
  - If cur_digits < DIGITS: value = value*10 + d, and cur_digits increments. Leading zeros count as digits.
  - Otherwise: reject the key and pulse key_err. The value is unchanged.
- A (enter):
  - If cur_digits == 0: reject with key_err.
  - Otherwise: set slot_valid[cur_slot] and store cur_digits in the per-slot digit count.
  - If cur_slot == NUM_SLOTS-1: go to DONE and pulse done. cur_slot holds its value.
  - Otherwise: cur_slot increments and cur_digits = 0.
- B (backspace):
  - If cur_digits > 0: value = value/10 (integer division) and cur_digits decrements.
  - If cur_digits == 0 and cur_slot > 0: reopen the previous slot. cur_slot decrements, that slot's valid flag clears, and cur_digits is restored from its stored count. The value is untouched.
  - If cur_digits == 0 and cur_slot == 0: reject with key_err.
- C (clear): current slot value = 0 and cur_digits = 0. No error even if already empty.
- D, E, F: ignored with no error.
- DONE holds all slots and flags until start or restart.
- Arithmetic: value*10 + d is computed at VAL_W+4 bits. By the parameter rule it never exceeds 2**VAL_W-1, and the result is truncated to VAL_W bits.

## Timing
- All outputs are registered.
- A key strobe at cycle n updates state and outputs at edge n+1. done and key_err are high for exactly cycle n+1.
- Back-to-back strobes on consecutive cycles are each processed.
- An asserted rst clears outputs immediately (asynchronously). After release, the first active edge is normal operation.
- restart or start coincident with key_strobe: the key is dropped and no key_err is raised.
- rst mid-entry discards all partial data.

## Test plan
- Reset, start, then keys 1,2,A,3,A,4,A,0,7,A: slots = {7,4,3,12} (slot3..slot0). slot_valid=4'hF. done pulses once on the cycle after the last A. entering drops.
- In ENTRY with DIGITS=2, keys 9,9,9: third key raises key_err for one cycle. Value 99, cur_digits=2.
- Keys 5,A,B: cur_slot returns to 0 with slot_valid[0]=0 and cur_digits=1. Then B gives value 0, cur_digits 0. Then B again raises key_err.
- Keys 4,2,C,A: C zeroes the slot, and A raises key_err because cur_digits is 0.
- restart and key_strobe (digit 3) in the same cycle mid-entry: IDLE, all outputs 0, no key_err. Next key strobe is ignored.
- rst asserted mid-cycle during ENTRY: outputs go to 0 before the next clock edge. Sweep NUM_SLOTS=8, DIGITS=3 with keys 9,9,9 per slot, expecting each slot = 999 and done after 8 commits.
